// File: rtl/fps_disp_pkg.sv
// Shared types and constants for the HEX display arbiter: FSM state
// encoding, segment patterns and the display clamp limit.
package fps_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CONV = 2'd2,
    ST_SHOW = 2'd3
  } state_t;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Largest value the two digits can show; anything above is clamped.
  localparam int MAX_DISP = 99;

  // Decimal digit to active-low segments {g..a}; codes 10..15 render blank.
  function automatic logic [6:0] seg_table(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// Combinational BCD digit to active-low 7-segment encoder. The parent
// registers the result so both digits change on the same edge.
module seg7_digit_enc
  import fps_disp_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  assign o_seg = seg_table(i_digit);

endmodule

// File: rtl/hex_disp_arbiter.sv
// Round-robin owner of the two HEX digits. The granted source's value is
// sampled once, clamped to 99, split into tens/units by repeated
// subtraction, and shown for a fixed dwell before the next arbitration.
module hex_disp_arbiter
  import fps_disp_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int DWELL = 50000000
) (
  input  logic               clk50,
  input  logic               reset_n,
  input  logic [N_SRC-1:0]   req,
  input  logic [8*N_SRC-1:0] value,
  output logic [N_SRC-1:0]   grant,
  output logic [2:0]         sel,
  output logic [6:0]         hex_h,
  output logic [6:0]         hex_l,
  output logic               ovf
);

  localparam int                 DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]      DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N_SRC-1:0]   GRANT_ONE  = {{(N_SRC-1){1'b0}}, 1'b1};

  // First requester strictly after 'last', wrapping; 'last' itself is
  // checked at the end so a sole requester is re-granted.
  function automatic logic [2:0] rr_pick(input logic [N_SRC-1:0] req_v,
                                         input logic [2:0]       last);
    logic [2:0]       win;
    logic             found;
    logic [N_SRC-1:0] sh;
    int               idx;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = (int'(last) + k) % N_SRC;
      sh  = req_v >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
    return win;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N_SRC-1:0]  r_grant;
  logic [2:0]        r_sel;
  logic [2:0]        r_ptr;      // last winner; search starts after it
  logic [6:0]        r_rem;
  logic [3:0]        r_tens;
  logic              r_ovf_n;    // overflow of the value being converted
  logic [DW-1:0]     r_dwell;
  logic [6:0]        r_hex_h;
  logic [6:0]        r_hex_l;
  logic              r_ovf;

  logic              w_any;
  logic              w_owner_req;
  logic [2:0]        w_win;
  logic [8*N_SRC-1:0] w_val_sh;
  logic [7:0]        w_val;
  logic [6:0]        w_seg_h;
  logic [6:0]        w_seg_l;
  logic              w_rearb;
  logic              w_take;
  logic              w_blank;
  logic              w_load;
  logic              w_step;
  logic              w_show;

  assign w_any       = |req;
  assign w_owner_req = |(req & r_grant);
  assign w_win       = rr_pick(req, r_ptr);
  assign w_val_sh    = value >> {r_sel, 3'b000};
  assign w_val       = w_val_sh[7:0];

  seg7_digit_enc u_enc_tens (
    .i_digit (r_tens),
    .o_seg   (w_seg_h)
  );

  seg7_digit_enc u_enc_units (
    .i_digit (r_rem[3:0]),
    .o_seg   (w_seg_l)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_rearb     = 1'b0;
    w_take      = 1'b0;
    w_blank     = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_show      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_LOAD;
          w_take      = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!w_owner_req) begin
          w_rearb = 1'b1;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = ST_CONV;
        end
      end
      ST_CONV: begin
        if (!w_owner_req) begin
          w_rearb = 1'b1;
        end else if (r_rem >= 7'd10) begin
          w_step = 1'b1;
        end else begin
          w_show      = 1'b1;
          w_state_nxt = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (!w_owner_req || (r_dwell == DWELL_LAST)) begin
          w_rearb = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_blank     = 1'b1;
      end
    endcase
    // Dwell expiry and owner abort share one arbitration outcome.
    if (w_rearb) begin
      if (w_any) begin
        w_state_nxt = ST_LOAD;
        w_take      = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
        w_blank     = 1'b1;
      end
    end
  end

  // Grant, pointer and displayed outputs.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= 3'(N_SRC - 1);
      r_hex_h <= SEG_BLANK;
      r_hex_l <= SEG_BLANK;
      r_ovf   <= 1'b0;
    end else begin
      if (w_take) begin
        r_grant <= GRANT_ONE << w_win;
        r_sel   <= w_win;
        r_ptr   <= w_win;
      end else if (w_blank) begin
        r_grant <= '0;
      end
      if (w_blank) begin
        r_hex_h <= SEG_BLANK;
        r_hex_l <= SEG_BLANK;
        r_ovf   <= 1'b0;
      end else if (w_show) begin
        r_hex_h <= w_seg_h;
        r_hex_l <= w_seg_l;
        r_ovf   <= r_ovf_n;
      end
    end
  end

  // Value capture and binary-to-BCD conversion by repeated subtraction.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_rem   <= '0;
      r_tens  <= '0;
      r_ovf_n <= 1'b0;
    end else if (w_load) begin
      r_rem   <= (w_val > 8'(MAX_DISP)) ? 7'(MAX_DISP) : w_val[6:0];
      r_ovf_n <= (w_val > 8'(MAX_DISP));
      r_tens  <= '0;
    end else if (w_step) begin
      r_rem   <= r_rem - 7'd10;
      r_tens  <= r_tens + 4'd1;
    end
  end

  // Dwell counter: cleared on SHOW entry, saturates at the last count.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_dwell <= '0;
    end else if (w_show) begin
      r_dwell <= '0;
    end else if ((r_state == ST_SHOW) && (r_dwell != DWELL_LAST)) begin
      r_dwell <= r_dwell + 1'b1;
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign hex_h = r_hex_h;
  assign hex_l = r_hex_l;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_hex_disp_arbiter.sv
// Self-checking bench for hex_disp_arbiter (N_SRC=4, DWELL=8). Expected
// displays are queued as stimulus is applied and compared on each SHOW entry.
module tb_hex_disp_arbiter;
  import fps_disp_pkg::*;

  localparam int N_SRC = 4;
  localparam int DWELL = 8;

  logic               clk50;
  logic               reset_n;
  logic [N_SRC-1:0]   req;
  logic [8*N_SRC-1:0] value;
  logic [N_SRC-1:0]   grant;
  logic [2:0]         sel;
  logic [6:0]         hex_h;
  logic [6:0]         hex_l;
  logic               ovf;

  hex_disp_arbiter #(
    .N_SRC (N_SRC),
    .DWELL (DWELL)
  ) dut (
    .clk50   (clk50),
    .reset_n (reset_n),
    .req     (req),
    .value   (value),
    .grant   (grant),
    .sel     (sel),
    .hex_h   (hex_h),
    .hex_l   (hex_l),
    .ovf     (ovf)
  );

  typedef struct {
    logic [2:0] s;
    logic [6:0] h;
    logic [6:0] l;
    logic       o;
  } exp_t;

  exp_t   sb_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     show_cnt = 0;
  int     conv_run = 0;
  int     conv_len_last = 0;
  int     show_len = 0;
  bit     chk_dwell = 1'b0;
  state_t prev_st = ST_IDLE;

  initial begin
    clk50 = 1'b0;
    forever #10 clk50 = ~clk50;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int s, input logic [6:0] h, input logic [6:0] l, input logic o);
    exp_t e;
    e.s = 3'(s);
    e.h = h;
    e.l = l;
    e.o = o;
    sb_q.push_back(e);
  endtask

  task automatic set_val(input int i, input logic [7:0] v);
    value[8*i +: 8] = v;
  endtask

  // Per-cycle observer: one-hot grant, CONV length, SHOW length, scoreboard.
  task automatic monitor_step();
    state_t st;
    exp_t   e;
    st = dut.r_state;
    if (!reset_n) begin
      prev_st  = ST_IDLE;
      conv_run = 0;
      show_len = 0;
      return;
    end
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    if (st == ST_CONV) conv_run = (prev_st == ST_CONV) ? conv_run + 1 : 1;
    if (prev_st == ST_SHOW && st != ST_SHOW && chk_dwell)
      check("dwell_len", show_len, DWELL);
    if (st == ST_SHOW && prev_st != ST_SHOW) begin
      show_cnt++;
      conv_len_last = conv_run;
      show_len = 1;
      if (sb_q.size() == 0) begin
        check("sb_underflow", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check("sb_show", {10'b0, grant, sel, hex_h, hex_l, ovf},
              {10'b0, 4'(4'b0001 << e.s), e.s, e.h, e.l, e.o});
      end
    end else if (st == ST_SHOW) begin
      show_len++;
    end
    prev_st = st;
  endtask

  initial begin
    forever begin
      @(negedge clk50);
      monitor_step();
    end
  end

  // Step to just after the monitor's negedge sample.
  task automatic tick();
    @(negedge clk50);
    #1;
  endtask

  task automatic wait_shows(input int target, input int budget);
    int n = 0;
    while (show_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("reach_show", show_cnt, target);
  endtask

  task automatic do_reset();
    check("sb_drain", sb_q.size(), 0);
    sb_q.delete();
    chk_dwell = 1'b0;
    reset_n = 1'b0;
    req = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    req     = '0;
    value   = '0;
    tick();
    check("rst_grant", grant, 0);
    check("rst_sel", sel, 0);
    check("rst_hex", {hex_h, hex_l}, {7'h7F, 7'h7F});
    check("rst_ovf", ovf, 0);
    do_reset();

    // Reset mid-SHOW, then request-to-display latency from release.
    set_val(0, 8'd60);
    req = 4'b0001;
    push_exp(0, 7'h02, 7'h40, 1'b0);
    wait_shows(show_cnt + 1, 30);
    tick();
    tick();
    check("sb_drain_rst", sb_q.size(), 0);
    reset_n = 1'b0;
    tick();
    check("rst_mid_grant", grant, 0);
    check("rst_mid_hex", {hex_h, hex_l}, {7'h7F, 7'h7F});
    check("rst_mid_ovf", ovf, 0);
    push_exp(0, 7'h02, 7'h40, 1'b0);
    reset_n = 1'b1;
    tick();
    check("rel_grant", grant, 4'b0001);
    n = 1;
    while ((hex_h != 7'h02 || hex_l != 7'h40) && n < 20) begin
      tick();
      n++;
    end
    check("rel_latency", n, 9);
    do_reset();

    // Four requesters: owners 0,1,2,3,0, each for exactly DWELL cycles.
    set_val(0, 8'd12);
    set_val(1, 8'd34);
    set_val(2, 8'd56);
    set_val(3, 8'd78);
    push_exp(0, 7'h79, 7'h24, 1'b0);
    push_exp(1, 7'h30, 7'h19, 1'b0);
    push_exp(2, 7'h12, 7'h02, 1'b0);
    push_exp(3, 7'h78, 7'h00, 1'b0);
    push_exp(0, 7'h79, 7'h24, 1'b0);
    chk_dwell = 1'b1;
    req = 4'b1111;
    wait_shows(show_cnt + 5, 200);
    chk_dwell = 1'b0;
    do_reset();

    // Sole requester: value change mid-SHOW only appears after refresh.
    set_val(2, 8'd5);
    push_exp(2, 7'h40, 7'h12, 1'b0);
    chk_dwell = 1'b1;
    req = 4'b0100;
    wait_shows(show_cnt + 1, 30);
    tick();
    set_val(2, 8'd93);
    push_exp(2, 7'h10, 7'h30, 1'b0);
    tick();
    tick();
    check("hold_old", {hex_h, hex_l}, {7'h40, 7'h12});
    wait_shows(show_cnt + 1, 40);
    chk_dwell = 1'b0;
    do_reset();

    // Overflow clamp, then a small value clears ovf.
    set_val(0, 8'd200);
    set_val(1, 8'd7);
    push_exp(0, 7'h10, 7'h10, 1'b1);
    push_exp(1, 7'h40, 7'h78, 1'b0);
    req = 4'b0011;
    wait_shows(show_cnt + 2, 80);
    do_reset();

    // Owner drops req in CONV: immediate re-grant, old digits held, then idle.
    set_val(0, 8'd11);
    set_val(1, 8'd50);
    set_val(3, 8'd42);
    push_exp(0, 7'h79, 7'h79, 1'b0);
    req = 4'b0001;
    wait_shows(show_cnt + 1, 30);
    req = 4'b1011;
    n = 0;
    while (grant != 4'b0010 && n < 20) begin
      tick();
      n++;
    end
    check("grant_src1", grant, 4'b0010);
    tick();
    req = 4'b1001;
    tick();
    check("abort_grant", grant, 4'b1000);
    check("abort_hold", {hex_h, hex_l}, {7'h79, 7'h79});
    push_exp(3, 7'h19, 7'h24, 1'b0);
    wait_shows(show_cnt + 1, 30);
    req = 4'b0000;
    tick();
    check("idle_grant", grant, 0);
    check("idle_blank", {hex_h, hex_l}, {7'h7F, 7'h7F});
    check("idle_ovf", ovf, 0);
    do_reset();

    // Conversion length bounds: 0 -> 1 CONV cycle, 99 -> 10 CONV cycles.
    set_val(0, 8'd0);
    set_val(1, 8'd99);
    push_exp(0, 7'h40, 7'h40, 1'b0);
    push_exp(1, 7'h10, 7'h10, 1'b0);
    req = 4'b0011;
    wait_shows(show_cnt + 1, 30);
    check("conv_len_0", conv_len_last, 1);
    wait_shows(show_cnt + 1, 40);
    check("conv_len_99", conv_len_last, 10);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
